wb_arb: RTL
===========

WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL have: alu_valid  in  1; alu_rd  in  5; alu_data  in  64  ALU writeback request.
REQ-004 SHALL have: alu_ready  out  1  ALU request granted this cycle.
REQ-005 SHALL have: lsu_valid  in  1; lsu_rd  in  5; lsu_data  in  64  load-unit writeback request.
REQ-006 SHALL have: lsu_ready  out  1  LSU request granted this cycle.
REQ-007 SHALL have: iss_valid  in  1; iss_rd  in  5  an instruction issued that will write iss_rd.
REQ-008 SHALL have: flush  in  1  synchronous clear of the scoreboard.
REQ-009 SHALL have: chk_rs1, chk_rs2  in  5 each  source registers to hazard-check.
REQ-010 SHALL have: busy1, busy2  out  1 each  source has a pending write.
REQ-011 SHALL have: wb_rd  out  5; wb_out  out  64  register-file write port (wb_rd=0 means no write).
REQ-012 SHALL have: pending  out  32  scoreboard bit vector.
REQ-013 SHALL have: dup_err  out  1  issue to an already-pending register.

Function
REQ-014 SHALL define a transfer as valid&ready on a requester in the same cycle.
REQ-015 SHALL, when exactly one requester is valid, assert its ready combinationally in that cycle.
REQ-016 SHALL, when both are valid, grant one by round-robin: a 1-bit last-grant pointer selects the other requester, and the ALU wins the first contest after reset.
REQ-017 SHALL update the pointer only on contested grants; uncontested grants leave it unchanged.
REQ-018 SHALL never assert both readys in one cycle, and SHALL never assert a ready without its valid.
REQ-019 SHALL, on a transfer, register rd and data to wb_rd/wb_out at the next posedge (latency 1); with no transfer, wb_rd<=0 and wb_out<=0.
REQ-020 SHALL accept transfers with rd=0 normally; these produce wb_rd=0 (no write).
REQ-021 SHALL set pending[iss_rd] at posedge when iss_valid and iss_rd!=0.
REQ-022 SHALL clear pending[rd] at the same posedge that loads a transfer's rd into wb_rd.
REQ-023 SHALL give set priority when a set and a clear of the same bit occur in one cycle.
REQ-024 SHALL hold pending[0]=0 at all times.
REQ-025 SHALL drive busy1=pending[chk_rs1] and busy2=pending[chk_rs2] combinationally, so that busy is 0 while wb_rd equals the checked register and the register file bypass covers it.
REQ-026 SHALL pulse dup_err high for one cycle at the posedge following an issue whose iss_rd!=0 already has its pending bit set; the bit stays set.
REQ-027 SHALL, on flush, clear all pending bits at posedge with priority over same-cycle sets, while the arbitration and wb output path continue unaffected.

Reset
REQ-028 SHALL, while rst=1, asynchronously force wb_rd=0, wb_out=0, pending=0, dup_err=0 and pointer=LSU-last (so the ALU wins next), and thereby busy1=busy2=0.
REQ-029 SHALL keep alu_ready and lsu_ready low while rst=1, regardless of valids.
REQ-030 SHALL abandon in-flight state on reset mid-operation, with no transfer recorded after rst deasserts.

Verification
REQ-031 SHALL cover: alu_valid alone, rd=5, data=0xA5 -> alu_ready=1 same cycle; next cycle wb_rd=5, wb_out=0xA5; following cycle wb_rd=0.
REQ-032 SHALL cover: both valid for 4 consecutive cycles after reset -> grants ALU, LSU, ALU, LSU.
REQ-033 SHALL cover: iss_valid rd=7, then chk_rs1=7 -> busy1=1; LSU transfers rd=7 -> busy1=0 on the cycle wb_rd=7.
REQ-034 SHALL cover: same cycle issue rd=3 and transfer rd=3 with pending[3]=1 -> pending[3] remains 1 and dup_err pulses.
REQ-035 SHALL cover: iss rd=0 and transfer rd=0 -> pending unchanged, wb_rd=0; then flush with pending=0xF0 -> pending=0 next cycle.
REQ-036 SHALL cover: rst asserted mid-cycle with wb_rd=9 -> wb_rd=0 and pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_arb.sv
// Purpose: two-requester writeback arbiter (ALU/LSU) with a register scoreboard for hazard checks.
// Latency: ready is combinational in the request cycle; wb_rd/wb_out are registered one cycle later.
// Backpressure: the loser of a contest sees ready low and holds its request; both readys stay low in reset.
module wb_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [63:0] alu_data,
   output logic        alu_ready,
   input  logic        lsu_valid,
   input  logic [4:0]  lsu_rd,
   input  logic [63:0] lsu_data,
   output logic        lsu_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic        flush,
   input  logic [4:0]  chk_rs1,
   input  logic [4:0]  chk_rs2,
   output logic        busy1,
   output logic        busy2,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_out,
   output logic [31:0] pending,
   output logic        dup_err
);

   // Last-grant pointer encoding: the requester NOT recorded here wins the next contest.
   localparam logic LAST_ALU = 1'b0;
   localparam logic LAST_LSU = 1'b1;

   logic        r_last;
   logic [31:0] r_pending;
   logic [4:0]  r_wb_rd;
   logic [63:0] r_wb_out;
   logic        r_dup_err;

   logic        w_contest;
   logic        w_alu_gnt;
   logic        w_lsu_gnt;
   logic        w_xfer;
   logic [4:0]  w_xfer_rd;
   logic [63:0] w_xfer_data;
   logic        w_iss_set;
   logic        w_dup;
   logic [31:0] w_pending_nxt;

   // Grant selection: uncontested requests pass straight through, contests follow the pointer.
   always_comb begin
      w_contest   = alu_valid & lsu_valid;
      w_alu_gnt   = ~rst & alu_valid & (~lsu_valid | (r_last == LAST_LSU));
      w_lsu_gnt   = ~rst & lsu_valid & (~alu_valid | (r_last == LAST_ALU));
      w_xfer      = w_alu_gnt | w_lsu_gnt;
      w_xfer_rd   = w_lsu_gnt ? lsu_rd   : alu_rd;
      w_xfer_data = w_lsu_gnt ? lsu_data : alu_data;
      w_iss_set   = iss_valid & (iss_rd != 5'd0);
      w_dup       = w_iss_set & r_pending[iss_rd];
   end

   // Scoreboard next state: clear on writeback, set wins over clear, flush wins over everything.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_xfer)
         w_pending_nxt[w_xfer_rd] = 1'b0;
      if (w_iss_set)
         w_pending_nxt[iss_rd] = 1'b1;
      if (flush)
         w_pending_nxt = '0;
      w_pending_nxt[0] = 1'b0;
   end

   // Round-robin pointer moves only when both requesters competed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_last <= LAST_LSU;
      else if (w_contest && w_xfer)
         r_last <= w_lsu_gnt ? LAST_LSU : LAST_ALU;
   end

   // Writeback register: loads the granted request, otherwise returns to idle zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_rd  <= 5'd0;
         r_wb_out <= 64'd0;
      end else if (w_xfer) begin
         r_wb_rd  <= w_xfer_rd;
         r_wb_out <= w_xfer_data;
      end else begin
         r_wb_rd  <= 5'd0;
         r_wb_out <= 64'd0;
      end
   end

   // Scoreboard and duplicate-issue pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_dup_err <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_dup_err <= w_dup;
      end
   end

   assign alu_ready = w_alu_gnt;
   assign lsu_ready = w_lsu_gnt;
   assign wb_rd     = r_wb_rd;
   assign wb_out    = r_wb_out;
   assign pending   = r_pending;
   assign dup_err   = r_dup_err;
   // Same-edge clear means the checked register reads not-busy while the bypass holds it.
   assign busy1     = r_pending[chk_rs1];
   assign busy2     = r_pending[chk_rs2];

endmodule
